// File: rtl/fix_pkg.sv
// fix_pkg: shared FIX byte-reader constants, count type and word/byte helper
package fix_pkg;
  localparam logic [7:0] FIX_SOH = 8'h01;
  localparam int FIX_BYTE_W = 8;
  typedef logic [1:0] cnt_t;
  function automatic int bytes_per_word(input int data_width);
    return data_width / FIX_BYTE_W;
  endfunction
endpackage

// File: rtl/fix_fifo_byte_reader_if.sv
// fix_fifo_byte_reader_if: FIFO read port plus byte stream toward the FIX parser
// master = reader side (drives rd_cs/rd_en and the byte stream), slave = FIFO + parser side
interface fix_fifo_byte_reader_if import fix_pkg::*; #(parameter int DATA_WIDTH = 32) ();
  logic fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic fifo_rd_cs_o;
  logic fifo_rd_en_o;
  logic [FIX_BYTE_W-1:0] byte_o;
  logic byte_valid_o;
  logic byte_ready_i;
  logic soh_o;
  logic last_in_word_o;
  modport master (
    input fifo_empty_i, fifo_data_i, byte_ready_i,
    output fifo_rd_cs_o, fifo_rd_en_o, byte_o, byte_valid_o, soh_o, last_in_word_o
  );
  modport slave (
    output fifo_empty_i, fifo_data_i, byte_ready_i,
    input fifo_rd_cs_o, fifo_rd_en_o, byte_o, byte_valid_o, soh_o, last_in_word_o
  );
endinterface

// File: rtl/fix_rd_prefetch.sv
// fix_rd_prefetch: 2-entry word store (current + prefetch) with capture steering and pop
// cap/cap_data: returning FIFO word; pop: last byte of cur_word leaves; cur_word/stored: head word and fill count
module fix_rd_prefetch import fix_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] cur_word,
  output cnt_t                  stored
);
  logic [DATA_WIDTH-1:0] pf_word;
  logic to_cur;
  logic shift;
  // A returning word lands directly in cur_word when the head is empty or is leaving this cycle
  always_comb begin
    to_cur = cap && (stored == 2'd0 || (stored == 2'd1 && pop));
    shift = pop && stored == 2'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stored <= '0;
      cur_word <= '0;
      pf_word <= '0;
    end else begin
      stored <= stored + cnt_t'(cap) - cnt_t'(pop);
      if (to_cur || shift) cur_word <= shift ? pf_word : cap_data;
      if (cap && !to_cur) pf_word <= cap_data;
    end
  end
endmodule

// File: rtl/fix_fifo_byte_reader.sv
// fix_fifo_byte_reader: pops FIX ingress FIFO words and streams them MSB byte first, flagging SOH
// clk/rst: clock and sync active-high reset; bus: FIFO read port and valid/ready byte stream
module fix_fifo_byte_reader import fix_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = FIX_BYTE_W,
  parameter logic [BYTE_WIDTH-1:0] SOH_CHAR = FIX_SOH
) (
  input logic clk,
  input logic rst,
  fix_fifo_byte_reader_if.master bus
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW = BPW > 1 ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST = IW'(BPW - 1);
  logic inflight;
  logic rst_q;
  logic last;
  logic xfer;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] cur_word;
  cnt_t stored;
  // rst_q keeps every output low for the cycle right after reset
  always_comb begin
    bus.fifo_rd_en_o = !rst && !rst_q && !bus.fifo_empty_i && !inflight && stored != 2'd2;
    bus.fifo_rd_cs_o = bus.fifo_rd_en_o;
    bus.byte_valid_o = !rst && stored != 2'd0;
    bus.byte_o = bus.byte_valid_o ? BYTE_WIDTH'(cur_word >> (FIX_BYTE_W * (BPW - 1 - int'(idx)))) : '0;
    last = idx == LAST;
    bus.last_in_word_o = bus.byte_valid_o && last;
    bus.soh_o = bus.byte_valid_o && bus.byte_o == SOH_CHAR;
    xfer = bus.byte_valid_o && bus.byte_ready_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      idx <= '0;
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      inflight <= bus.fifo_rd_en_o;
      if (xfer) idx <= last ? '0 : idx + 1'b1;
    end
  end
  fix_rd_prefetch #(.DATA_WIDTH(DATA_WIDTH)) u_pf (
    .clk(clk),
    .rst(rst),
    .cap(inflight),
    .cap_data(bus.fifo_data_i),
    .pop(xfer && last),
    .cur_word(cur_word),
    .stored(stored)
  );
endmodule

// File: tb/tb_fix_fifo_byte_reader.sv
// tb_fix_fifo_byte_reader: table vectors, corner sequences and random traffic against a byte-queue model
module tb_fix_fifo_byte_reader;
  import fix_pkg::*;
  typedef struct { bit restart; bit ready; bit rd; bit valid; logic [7:0] b; bit soh; bit last; } vec_t;
  typedef struct { logic [7:0] b; bit last; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fix_fifo_byte_reader_if #(.DATA_WIDTH(32)) bus ();
  fix_fifo_byte_reader #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [31:0] fq[$];
  exp_t expq[$];
  logic [7:0] got[$];
  logic [7:0] sb[$];
  int pops = 0, done_w = 0;
  int nrd, nvalid, nsoh, nlast, cyc, first_v, last_v;
  bit rd_prev = 1'b0;
  bit rstq_m = 1'b1;
  bit force_empty = 1'b0;
  vec_t vec[25];
  vec_t nil;
  logic [7:0] abcd[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rs, bit r, bit rd, bit v, logic [7:0] b, bit s, bit l);
    vec_t x;
    x.restart = rs; x.ready = r; x.rd = rd; x.valid = v; x.b = b; x.soh = s; x.last = l;
    return x;
  endfunction

  task automatic drive_inputs();
    bus.fifo_empty_i = force_empty || fq.size() == 0;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    for (int i = 3; i >= 0; i--) sb.push_back(w[8*i +: 8]);
    drive_inputs();
  endtask

  task automatic clr_stats();
    nrd = 0; nvalid = 0; nsoh = 0; nlast = 0; cyc = 0; first_v = -1; last_v = -1;
    got.delete();
    sb.delete();
  endtask

  // One clock: check outputs at the falling edge, then advance the model and the FIFO at the rising edge
  task automatic step_core(input bit use_row, input vec_t row);
    bit rd_s, v_s, r_s, rst_s, have_w, exp_v, exp_rd;
    int stored_m;
    exp_t e;
    logic [31:0] w;
    have_w = 1'b0;
    w = '0;
    @(negedge clk);
    rst_s = rst;
    rd_s = bus.fifo_rd_en_o;
    v_s = bus.byte_valid_o;
    r_s = bus.byte_ready_i;
    stored_m = pops - done_w - int'(rd_prev);
    exp_v = !rst && stored_m > 0;
    exp_rd = !rst && !rstq_m && !bus.fifo_empty_i && !rd_prev && stored_m < 2;
    chk("rd_en", 32'(rd_s), 32'(exp_rd));
    chk("rd_cs", 32'(bus.fifo_rd_cs_o), 32'(exp_rd));
    chk("valid", 32'(v_s), 32'(exp_v));
    if (v_s && expq.size() > 0) begin
      e = expq[0];
      chk("byte", 32'(bus.byte_o), 32'(e.b));
      chk("soh", 32'(bus.soh_o), 32'(e.b == 8'h01));
      chk("last", 32'(bus.last_in_word_o), 32'(e.last));
    end else begin
      chk("soh_idle", 32'(bus.soh_o), 0);
      chk("last_idle", 32'(bus.last_in_word_o), 0);
    end
    if (rst || rstq_m) chk("byte_rst", 32'(bus.byte_o), 0);
    if (use_row) begin
      chk("row_rd", 32'(rd_s), 32'(row.rd));
      chk("row_valid", 32'(v_s), 32'(row.valid));
      if (row.valid) begin
        chk("row_byte", 32'(bus.byte_o), 32'(row.b));
        chk("row_soh", 32'(bus.soh_o), 32'(row.soh));
        chk("row_last", 32'(bus.last_in_word_o), 32'(row.last));
      end
    end
    nrd += int'(rd_s);
    nsoh += int'(bus.soh_o);
    nlast += int'(bus.last_in_word_o);
    if (v_s) begin
      nvalid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (v_s && r_s) got.push_back(bus.byte_o);
    cyc++;
    @(posedge clk);
    rstq_m = rst_s;
    if (rst_s) begin
      pops = 0; done_w = 0; rd_prev = 1'b0;
      expq.delete();
    end else begin
      if (rd_s && fq.size() > 0) begin
        w = fq.pop_front();
        have_w = 1'b1;
        pops++;
        for (int i = 3; i >= 0; i--) begin
          e.b = w[8*i +: 8];
          e.last = i == 0;
          expq.push_back(e);
        end
      end
      if (v_s && r_s && expq.size() > 0) begin
        e = expq.pop_front();
        if (e.last) done_w++;
      end
      rd_prev = rd_s;
    end
    #1;
    if (have_w) bus.fifo_data_i = w;
    drive_inputs();
  endtask

  task automatic step();
    step_core(1'b0, nil);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.delete();
    drive_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    bus.byte_ready_i = 1'b0;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i = '0;
    clr_stats();
    abcd[0] = 8'hAA; abcd[1] = 8'hBB; abcd[2] = 8'hCC; abcd[3] = 8'hDD;
    vec[0]  = mk(1, 1, 1, 0, 8'h00, 0, 0);
    vec[1]  = mk(0, 1, 0, 0, 8'h00, 0, 0);
    vec[2]  = mk(0, 1, 1, 1, 8'h38, 0, 0);
    vec[3]  = mk(0, 1, 0, 1, 8'h3D, 0, 0);
    vec[4]  = mk(0, 1, 0, 1, 8'h46, 0, 0);
    vec[5]  = mk(0, 1, 0, 1, 8'h49, 0, 1);
    vec[6]  = mk(0, 1, 0, 1, 8'h58, 0, 0);
    vec[7]  = mk(0, 1, 0, 1, 8'h2E, 0, 0);
    vec[8]  = mk(0, 1, 0, 1, 8'h34, 0, 0);
    vec[9]  = mk(0, 1, 0, 1, 8'h01, 1, 1);
    vec[10] = mk(0, 1, 0, 0, 8'h00, 0, 0);
    vec[11] = mk(1, 1, 1, 0, 8'h00, 0, 0);
    vec[12] = mk(0, 1, 0, 0, 8'h00, 0, 0);
    vec[13] = mk(0, 1, 1, 1, 8'h38, 0, 0);
    vec[14] = mk(0, 1, 0, 1, 8'h3D, 0, 0);
    vec[15] = mk(0, 0, 0, 1, 8'h46, 0, 0);
    vec[16] = mk(0, 0, 0, 1, 8'h46, 0, 0);
    vec[17] = mk(0, 0, 0, 1, 8'h46, 0, 0);
    vec[18] = mk(0, 1, 0, 1, 8'h46, 0, 0);
    vec[19] = mk(0, 1, 0, 1, 8'h49, 0, 1);
    vec[20] = mk(0, 1, 0, 1, 8'h58, 0, 0);
    vec[21] = mk(0, 1, 0, 1, 8'h2E, 0, 0);
    vec[22] = mk(0, 1, 0, 1, 8'h34, 0, 0);
    vec[23] = mk(0, 1, 0, 1, 8'h01, 1, 1);
    vec[24] = mk(0, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 25; i++) begin
      if (vec[i].restart) begin
        do_reset();
        clr_stats();
        push(32'h383D4649);
        push(32'h582E3401);
      end
      bus.byte_ready_i = vec[i].ready;
      step_core(1'b1, vec[i]);
      if (i == 10 || i == 24) chk("rd_pulses_2", nrd, 2);
    end
    // empty FIFO for 20 cycles, then an all-SOH word
    do_reset();
    clr_stats();
    bus.byte_ready_i = 1'b1;
    repeat (20) step();
    chk("empty_no_rd", nrd, 0);
    chk("empty_no_valid", nvalid, 0);
    clr_stats();
    push(32'h01010101);
    repeat (10) step();
    chk("soh_count", nsoh, 4);
    chk("soh_last_count", nlast, 1);
    chk("soh_bytes", got.size(), 4);
    // 8 words back-to-back: 32 bytes with no bubble
    do_reset();
    clr_stats();
    for (int i = 0; i < 8; i++) push($urandom);
    repeat (40) step();
    chk("stream_rd", nrd, 8);
    chk("stream_valid", nvalid, 32);
    chk("stream_span", last_v - first_v + 1, 32);
    chk("stream_bytes", got.size(), 32);
    // reset one cycle after a read issue, with the head word at byte 2
    do_reset();
    clr_stats();
    push(32'h11223344);
    repeat (4) step();
    push(32'h55667788);
    step();
    chk("pre_rst_rd", nrd, 2);
    chk("pre_rst_bytes", got.size(), 3);
    do_reset();
    clr_stats();
    push(32'hAABBCCDD);
    repeat (10) step();
    chk("post_rst_bytes", got.size(), 4);
    if (got.size() == 4) for (int i = 0; i < 4; i++) chk("post_rst_byte", 32'(got[i]), 32'(abcd[i]));
    // full store with ready toggling every cycle
    do_reset();
    clr_stats();
    for (int i = 0; i < 4; i++) push($urandom);
    for (int i = 0; i < 60; i++) begin
      bus.byte_ready_i = i[0];
      step();
    end
    chk("toggle_rd", nrd, 4);
    chk("toggle_bytes", got.size(), 16);
    if (got.size() == 16) for (int i = 0; i < 16; i++) chk("toggle_order", 32'(got[i]), 32'(sb[i]));
    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0 && fq.size() < 6) push($urandom);
      force_empty = $urandom_range(9) == 0;
      drive_inputs();
      bus.byte_ready_i = $urandom_range(3) != 0;
      if (i % 500 == 499) do_reset();
      else step();
    end
    force_empty = 1'b0;
    drive_inputs();
    bus.byte_ready_i = 1'b1;
    repeat (60) step();
    chk("drain_model", expq.size(), 0);
    chk("drain_fifo", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
